// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and FSM state type for the calc datapath
// Contents: WIDTH_DEF / DIGITS_DEF default sizes, state_e FSM encoding.
package calc_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int DIGITS_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit pre-shift adjust (+3 when >= 5)
// Ports: digit_i [3:0] BCD digit before the shift, digit_o [3:0] adjusted digit.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter
// Ports: clk, rst_n (async active-low); in_valid/in_ready/bin input handshake;
//        out_valid/out_ready output handshake with bcd (packed, units in [3:0])
//        and ndigits (count of significant digits, 1 for zero).
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int DIGITS = DIGITS_DEF,
    localparam int CW     = $clog2(WIDTH + 1),
    localparam int NW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [NW-1:0]         ndigits
);

    state_e                      state_q, state_d;
    logic                        alive_q;
    logic [WIDTH-1:0]            sr_q, sr_d;
    logic [4*DIGITS-1:0]         bcd_q, bcd_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [4*DIGITS-1:0]         bcd_adj;
    logic [4*DIGITS+WIDTH-1:0]   shifted;

    // alive_q keeps in_ready low while reset is held and for the release
    // edge itself, so acceptance can never race the reset deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (alive_q && in_valid)  state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CW'(1))      state_d = ST_DONE;
            ST_DONE:  if (out_ready)            state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && alive_q;
        out_valid = (state_q == ST_DONE);
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (bcd_q[4*g +: 4]),
                .digit_o (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    assign shifted = {bcd_adj, sr_q} << 1;

    always_comb begin
        sr_d  = sr_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && alive_q && in_valid) begin
            sr_d  = bin;
            bcd_d = '0;
            cnt_d = CW'(WIDTH);
        end else if (state_q == ST_SHIFT) begin
            {bcd_d, sr_d} = shifted;
            cnt_d         = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd = bcd_q;

    // Highest nonzero digit wins; a zero register reads as one digit.
    always_comb begin
        ndigits = NW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) ndigits = NW'(i + 1);
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    localparam int D = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] bcd;
    logic [3:0]  ndigits;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_out = 0;
    longint unsigned exp_q[$];
    bit drv_done;

    bin2bcd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .ndigits   (ndigits)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] ref_bcd(input longint unsigned v);
        logic [39:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_nd(input longint unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return 4'(n);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted values queue up, each presented result must match
    // the decimal expansion of the oldest outstanding value.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("mon_bcd", bcd, ref_bcd(exp_q[0]));
                    check("mon_ndigits", ndigits, ref_nd(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(longint'(bin));
                n_acc++;
            end
        end
    end

    // Offers v, keeps junk on bin/in_valid while busy, returns cycles from
    // the acceptance cycle to the first out_valid cycle.
    task automatic send(input logic [31:0] v, output int lat);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        if (!in_ready) check("send_ready_timeout", 0, 1);
        in_valid = 1'b1;
        bin      = v;
        tick();
        bin = $urandom();
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            bin = $urandom();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        check("rel_in_ready_same_cycle", in_ready, 0);
        tick();
        out_ready = 1'b0;
        check("rel_in_ready_next", in_ready, 1);
        check("rel_out_valid_next", out_valid, 0);
    endtask

    task automatic directed(input logic [31:0] v, input logic [39:0] eb, input logic [3:0] en);
        int lat;
        send(v, lat);
        check("dir_latency", lat, 33);
        check("dir_bcd", bcd, eb);
        check("dir_ndigits", ndigits, en);
        release_result();
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, g, seen, acc0, out0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = '0;
        drv_done  = 1'b0;

        // Pin the reference model with hand-computed values
        check("model_0", ref_bcd(0), 40'h0);
        check("model_prod", ref_bcd(64'd4294836225), 40'h4294836225);
        check("model_1234", ref_bcd(64'd1234), 40'h1234);
        check("model_nd_1234", ref_nd(64'd1234), 4'd4);
        check("model_nd_0", ref_nd(64'd0), 4'd1);

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_bcd", bcd, 0);
        check("rst_ndigits", ndigits, 1);
        in_valid = 1'b1;
        tick();
        tick();
        check("rst_in_ready_held", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // Zero, product, extremes and digit-count boundaries
        directed(32'd0, 40'h0, 4'd1);
        send(32'd4294836225, lat);
        check("prod_latency", lat, 33);
        check("prod_bcd", bcd, 40'h4294836225);
        check("prod_ndigits", ndigits, 4'd10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_bcd", bcd, 40'h4294836225);
            check("bp_ndigits", ndigits, 4'd10);
        end
        release_result();
        directed(32'hFFFF_FFFF, 40'h4294967295, 4'd10);
        directed(32'd1234, 40'h1234, 4'd4);
        directed(32'd1000000000, 40'h1000000000, 4'd10);
        directed(32'd9, 40'h9, 4'd1);
        directed(32'd10, 40'h10, 4'd2);

        // Reset during SHIFT cycle 10
        in_valid = 1'b1;
        bin      = 32'd12345;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_bcd", bcd, 0);
        check("mid_rst_ndigits", ndigits, 1);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", seen, 0);
        directed(32'd7, 40'h7, 4'd1);

        // Randomised back-to-back traffic
        acc0 = n_acc;
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [31:0] v;
                    bit acc;
                    int gg;
                    v = $urandom();
                    if (i % 97 == 0) v = 32'hFFFF_FFFF;
                    if (i % 89 == 0) v = 32'd0;
                    if (i % 7 == 0)  v = $urandom_range(0, 999);
                    for (int k = $urandom_range(0, 2); k > 0; k--) tick();
                    in_valid = 1'b1;
                    bin      = v;
                    acc = 1'b0;
                    gg  = 0;
                    while (!acc && gg < 200) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                        gg++;
                    end
                    if (!acc) check("rand_accept_timeout", 0, 1);
                    in_valid = 1'b0;
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
                g = 0;
                while (exp_q.size() > 0 && g < 200) begin
                    tick();
                    g++;
                end
                out_ready = 1'b0;
            end
        join
        check("rand_accepted", n_acc - acc0, 1000);
        check("rand_results", n_out - out0, 1000);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the width of the unsigned binary input (the product from mult16).
REQ-002 SHALL have parameter DIGITS, default 10, meaning the number of BCD output digits; DIGITS >= ceil(WIDTH*log10(2)) is required.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  bin holds a value to convert.
REQ-006 SHALL have port in_ready  output  1  block can accept a value this cycle.
REQ-007 SHALL have port bin  input  WIDTH  unsigned binary value.
REQ-008 SHALL have port out_valid  output  1  bcd and ndigits hold a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer (display driver) takes the result.
REQ-010 SHALL have port bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
REQ-011 SHALL have port ndigits  output  $clog2(DIGITS+1)  count of significant digits; 1 when the value is 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-014 IDLE: on in_valid=1, SHALL capture bin into a shift register, clear the BCD register to 0, load the bit counter with WIDTH, and go to SHIFT.
REQ-015 SHIFT: each cycle, SHALL add 3 to every BCD digit >= 5, then shift {bcd, shift register} left by one bit, then decrement the bit counter.
REQ-016 SHIFT SHALL last exactly WIDTH cycles and then go to DONE; out_valid SHALL first be high WIDTH+1 cycles after the acceptance cycle.
REQ-017 DONE: bcd and ndigits SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 DONE: on out_ready=1, SHALL return to IDLE on the next edge; a new value cannot be accepted in the same cycle.
REQ-019 ndigits SHALL be 1 + the index of the most significant nonzero digit, or 1 if all digits are zero.
REQ-020 Changes on bin or in_valid outside IDLE SHALL have no effect.
REQ-021 No digit of bcd SHALL ever exceed 9 in DONE.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, bcd=0, the shift register=0, the counter=0, and ndigits=1.
REQ-023 While rst_n=0, in_ready SHALL be 0; in_ready SHALL rise in the first cycle after release.
REQ-024 While rst_n=0, out_valid SHALL be 0.
REQ-025 Reset asserted during SHIFT or DONE SHALL abort the conversion; no partial result is ever presented.

Structure
REQ-026 SHALL take the state enum (IDLE/SHIFT/DONE) and the default WIDTH/DIGITS constants from the shared package calc_pkg.
REQ-027 SHALL instantiate a combinational sub-module bcd_digit_adj (4-bit in, 4-bit out, +3 when >= 5), one per digit.
REQ-028 SHALL contain no divider and no multi-cycle combinational path beyond one adjust stage plus a shift.

Verification
REQ-029 Zero: bin=0 -> after 33 cycles out_valid=1, bcd=40'h0, ndigits=1.
REQ-030 Mult16 product: 65535*65535 -> bin=4294836225 -> bcd=40'h4294836225, ndigits=10.
REQ-031 Max and small values: bin=32'hFFFFFFFF -> bcd=40'h4294967295, ndigits=10; bin=1234 -> bcd=40'h1234, ndigits=4.
REQ-032 Backpressure: hold out_ready=0 for 20 cycles after out_valid -> result unchanged, in_ready=0 throughout; out_ready=1 -> in_ready=1 on the following cycle.
REQ-033 Reset mid-operation: assert rst_n=0 in SHIFT cycle 10 -> out_valid never rises for that value; after release, bin=7 converts to bcd=40'h7, ndigits=1.
REQ-034 Randomised back-to-back: 1000 random values with random in_valid/out_ready gaps -> every bcd equals a decimal reference, and no value is lost or duplicated.
